// File: rtl/mining_pkg.sv
// ---------------------------------------------------------------------------
// mining_pkg
// Shared definitions for the mining control path and the datapath units it
// drives (preprocessing and compression).
//   HASH_W   : width of hashes and difficulty targets.
//   state_t  : 3-bit sequencer state codes; these exact codes appear on the
//              sequencer's state output and are decoded by the datapath.
//   sat_inc32: saturating 32-bit increment used by the attempt counter.
// ---------------------------------------------------------------------------
package mining_pkg;

  localparam int HASH_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_NONCE = 3'd2,
    ST_FETCH = 3'd3,
    ST_SCHED = 3'd4,
    ST_COMP  = 3'd5,
    ST_FINAL = 3'd6,
    ST_CHECK = 3'd7
  } state_t;

  // Counts up but sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hash_lt_target.sv
// ---------------------------------------------------------------------------
// hash_lt_target
// Purely combinational unsigned magnitude compare of a hash against the
// difficulty target. The sequencer only consults the result in CHECK, which
// is the cycle in which the hash from the datapath is stable.
// Ports:
//   hash   in  W  hash from the compression datapath
//   target in  W  difficulty target
//   lt     out 1  high when hash < target (unsigned)
// ---------------------------------------------------------------------------
module hash_lt_target
  import mining_pkg::*;
#(
  parameter int W = HASH_W
) (
  input  logic [W-1:0] hash,
  input  logic [W-1:0] target,
  output logic         lt
);

  // A full-width unsigned compare; both operands are declared unsigned.
  assign lt = (hash < target);

endmodule

// File: rtl/mining_sequencer.sv
// ---------------------------------------------------------------------------
// mining_sequencer
// Control FSM for a proof-of-work mining engine. It accepts a message one
// 512-bit block per cycle, then repeatedly steps the datapath through
// NONCE -> (FETCH, SCHED, COMP) per block -> FINAL -> CHECK until the hash
// beats the target, the attempt limit is hit, or the job is aborted.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle pulse that begins a job (IDLE only)
//   abort                 cancels the current job, no done/found pulse
//   load_valid, load_last message block handshake during LOAD
//   max_attempts          attempt limit, 0 = unlimited
//   target, hash          difficulty target and datapath hash result
//   state                 current state code to the datapath units
//   wr_addr               block write address / last-block index
//   stopw                 write inhibit (low only while a block is written)
//   load_ready            high in LOAD
//   busy                  job in progress
//   done, found           one-cycle end-of-job pulses
//   err                   sticky message-memory overflow flag
//   attempts              completed attempts, saturating
// ---------------------------------------------------------------------------
module mining_sequencer
  import mining_pkg::*;
#(
  parameter int DEPTH  = 2000,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [31:0]       max_attempts,
  input  logic [255:0]      target,
  input  logic [255:0]      hash,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              stopw,
  output logic              load_ready,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              err,
  output logic [31:0]       attempts
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   chunk_q, chunk_d;
  logic [31:0]         attempts_q, attempts_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic                hash_lt;
  logic [31:0]         attempts_inc;

  // The compare is evaluated every cycle but only acted on in CHECK.
  hash_lt_target #(
    .W(HASH_W)
  ) u_cmp (
    .hash  (hash),
    .target(target),
    .lt    (hash_lt)
  );

  assign attempts_inc = sat_inc32(attempts_q);

  // State and datapath-control registers. Reset wins over every other input,
  // including start and abort, and returns all outputs to their idle values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      chunk_q    <= '0;
      attempts_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      chunk_q    <= chunk_d;
      attempts_q <= attempts_d;
      err_q      <= err_d;
      done_q     <= done_d;
      found_q    <= found_d;
    end
  end

  // Next-state logic. Abort is checked first so it overrides every
  // transition; done/found default low so they only ever pulse for a cycle.
  // In LOAD the address holds on the last block so it ends up equal to the
  // index of the final block, which COMP then uses as the chunk limit.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    chunk_d    = chunk_q;
    attempts_d = attempts_q;
    err_d      = err_q;
    done_d     = 1'b0;
    found_d    = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_LOAD;
            wr_addr_d  = '0;
            attempts_d = '0;
            err_d      = 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (load_last) begin
              state_d = ST_NONCE;
            end else if (wr_addr_q == LAST_ADDR) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
          end
        end
        ST_NONCE: begin
          chunk_d = '0;
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          state_d = ST_SCHED;
        end
        ST_SCHED: begin
          state_d = ST_COMP;
        end
        ST_COMP: begin
          if (chunk_q < wr_addr_q) begin
            chunk_d = chunk_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FINAL;
          end
        end
        ST_FINAL: begin
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          attempts_d = attempts_inc;
          if (hash_lt) begin
            found_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if ((max_attempts != 32'd0) && (attempts_inc == max_attempts)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NONCE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign wr_addr    = wr_addr_q;
  assign load_ready = (state_q == ST_LOAD);
  assign stopw      = ~(load_ready & load_valid);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign found      = found_q;
  assign err        = err_q;
  assign attempts   = attempts_q;

endmodule

// File: doc/mining_sequencer.md
MINING_SEQUENCER -- requirements
Module: mining_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2000, meaning message memory depth in 512-bit blocks.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning write-address width.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job.
- abort  in  1  cancels the current job.
- load_valid  in  1  message block present on the datapath bus this cycle.
- load_last  in  1  the current block is the final block of the message.
- max_attempts  in  32  nonce attempt limit; 0 means unlimited.
- target  in  256  difficulty target.
- hash  in  256  HASH from the compression datapath.
- state  out  3  datapath state code driven to the preprocessing and compression units.
- wr_addr  out  ADDR_W  block address; also the last-block index.
- stopw  out  1  write inhibit.
- load_ready  out  1  high in LOAD.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-end pulse.
- found  out  1  one-cycle pulse together with done on success.
- err  out  1  sticky overflow flag.
- attempts  out  32  completed attempts.

Function
REQ-004 SHALL implement FSM IDLE(0), LOAD(1), NONCE(2), FETCH(3), SCHED(4), COMP(5), FINAL(6), CHECK(7); state output = FSM code.
REQ-005 IDLE: start=1 SHALL go to LOAD and clear wr_addr, attempts, err; start SHALL be ignored when not IDLE.
REQ-006 LOAD: stopw = ~load_valid; each load_valid cycle writes one block at wr_addr.
REQ-007 LOAD: wr_addr SHALL increment after each accepted non-last block and hold on the last block.
REQ-008 LOAD: an accepted load_last SHALL go to NONCE.
REQ-009 LOAD: an accepted non-last block at wr_addr==DEPTH-1 SHALL set err, pulse done, and go to IDLE.
REQ-010 NONCE SHALL last one cycle (datapath increments nonce, reloads H) and then go to FETCH; the chunk counter SHALL clear.
REQ-011 FETCH, then SCHED, then COMP, one cycle each.
REQ-012 COMP SHALL go to FETCH (chunk counter +1) when chunk counter < wr_addr, else to FINAL.
REQ-013 FINAL SHALL last one cycle and then go to CHECK; hash SHALL be sampled only in CHECK.
REQ-014 CHECK SHALL increment attempts, saturating at 2^32-1.
REQ-015 CHECK: hash < target (unsigned 256-bit) SHALL pulse found and done and go to IDLE.
REQ-016 CHECK: otherwise, if max_attempts≠0 and the new attempts value = max_attempts, done SHALL pulse with found=0 and the FSM SHALL go to IDLE; else it SHALL go to NONCE.
REQ-017 Attempt latency SHALL be 3 + 3*(wr_addr+1) cycles from NONCE entry to CHECK exit.
REQ-018 abort in any non-IDLE state SHALL go to IDLE on the next edge with no done or found pulse; abort SHALL take priority over all transitions.
REQ-019 busy = (FSM≠IDLE); stopw SHALL be 1 outside LOAD.
REQ-020 The first hashed nonce SHALL be the loaded nonce +1.

Reset
REQ-021 reset SHALL force IDLE, state=0, wr_addr=0, stopw=1, load_ready=0, busy=0, done=0, found=0, err=0, attempts=0 at the next edge, overriding start and abort, in any state.

Structure
REQ-022 Package mining_pkg SHALL hold the 3-bit state-code constants and the 256-bit width constant, shared with the datapath units.
REQ-023 The 256-bit comparison SHALL be sub-module hash_lt_target (combinational, registered-input use only in CHECK).

Verification
REQ-024 One block, target=all-ones -> state trace 1,2,3,4,5,6,7,0; found=done=1 in the cycle after CHECK; attempts=1.
REQ-025 One block, target=0, max_attempts=3 -> three NONCE..CHECK passes of 6 cycles each; done=1, found=0, attempts=3.
REQ-026 Three blocks (wr_addr=2), target=all-ones -> trace 2,3,4,5,3,4,5,3,4,5,6,7; attempt = 12 cycles.
REQ-027 load_valid pattern 1,0,1(last) -> stopw 0,1,0; wr_addr 0→1, held during the gap; then NONCE.
REQ-028 abort asserted in COMP -> IDLE next cycle, done=0, found=0; a subsequent start is accepted.
REQ-029 reset in SCHED -> all outputs at reset values next cycle; start while busy ignored; DEPTH=4 with 5 non-last blocks -> err=1, done pulse.
